// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//   Instruction-fetch front end feeding the IF/ID register. Owns the fetch PC,
//   issues one word fetch at a time over a req/gnt/rvalid handshake, and
//   buffers returned instructions (with their PC+4) in a show-ahead FIFO that
//   the ID stage drains under valid/ready. A branch redirect flushes the FIFO,
//   retires any in-flight fetch as stale and restarts fetching at the target.
//
// Ports
//   clk_i, rst_n            clock (rising edge), async active-low reset
//   redirect_i/_pc_i        taken branch/jump and its word-aligned target
//   imem_req_o/addr_o       fetch request and address (= fetch PC)
//   imem_gnt_i              request accepted this cycle
//   imem_rvalid_i/rdata_i   fetch response, at least one cycle after grant
//   instr_valid_o           FIFO head valid for ID
//   instr_o, pc_o           head instruction and its PC+4
//   instr_ready_i           ID accepts the head (0 = stall)
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("if_fetch_queue: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req, push, pop;

  logic [PW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d, count_left;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   head_instr_q, head_pc_q;

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    req        = 1'b0;
    push       = 1'b0;
    case (state_q)
      S_REQ: begin
        // rvalid here is never ours: it belongs to a fetch killed by reset
        req = (count_q < DEPTH_C) && !redirect_i;
        if (req && imem_gnt_i) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i)
          state_d = imem_rvalid_i ? S_REQ : S_DROP;
        else if (imem_rvalid_i) begin
          push    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    if (redirect_i) fetch_pc_d = redirect_pc_i;
  end

  assign imem_req_o  = req && rst_n;
  assign imem_addr_o = fetch_pc_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------------
  assign instr_valid_o = (count_q != '0) && !redirect_i;
  assign pop           = instr_valid_o && instr_ready_i;
  assign rd_ptr_d      = rd_ptr_q + PW'(pop);
  assign count_left    = count_q - (PW+1)'(pop);
  assign count_d       = count_left + (PW+1)'(push);

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata_i;
      pc_mem[wr_ptr_q]    <= req_pc_q + 32'd4;
    end
  end

  // Head is kept in its own register so the outputs hold their last value
  // when the FIFO drains or is flushed. If the FIFO would otherwise be empty
  // after this cycle's pop, the entry being pushed becomes the new head.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
    end else if (redirect_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_q + PW'(push);
      if (count_d != '0) begin
        if (push && count_left == '0) begin
          head_instr_q <= imem_rdata_i;
          head_pc_q    <= req_pc_q + 32'd4;
        end else begin
          head_instr_q <= instr_mem[rd_ptr_d];
          head_pc_q    <= pc_mem[rd_ptr_d];
        end
      end
    end
  end

  assign instr_o = head_instr_q;
  assign pc_o    = head_pc_q;

  // Requests are only issued with room left and count cannot rise while a
  // fetch is outstanding, so a push into a full FIFO is a design bug.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n)
    !(push && count_q == DEPTH_C));

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XMASK    = 32'hA5A5_0000;

  logic        clk_i = 1'b0, rst_n = 1'b0;
  logic        redirect_i = 1'b0, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0, instr_ready_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, imem_rdata_i = '0;
  logic        imem_req_o, instr_valid_o;
  logic [31:0] imem_addr_o, instr_o, pc_o;

  always #5 clk_i = ~clk_i;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o),
    .instr_ready_i(instr_ready_i)
  );

  int checks = 0, failures = 0;

  // Reference model: queue of {pc+4, instr}, fetch PC, one outstanding fetch
  // that may have been made stale by a redirect.
  logic [63:0] q[$];
  logic [31:0] fetch_pc, pend_pc;
  bit          outst, stale;
  logic [63:0] last_head;
  logic        exp_req, exp_valid;
  logic [31:0] exp_addr, exp_instr, exp_pc;

  // Memory environment: responds lat cycles after grant with addr ^ XMASK.
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  int          lat_min = 1, lat_max = 1;

  function automatic void model_reset();
    q.delete();
    fetch_pc  = RESET_PC;
    pend_pc   = '0;
    outst     = 0;
    stale     = 0;
    last_head = '0;
  endfunction

  function automatic string diff_str();
    return $sformatf("got req=%b addr=%h v=%b instr=%h pc=%h want req=%b addr=%h v=%b instr=%h pc=%h",
      imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
      exp_req, exp_addr, exp_valid, exp_instr, exp_pc);
  endfunction

  // Apply one cycle of inputs at the falling edge and predict the outputs.
  task automatic drive(input bit redir, input logic [31:0] rpc, input bit gnt, input bit rdy);
    @(negedge clk_i);
    redirect_i    = redir;
    redirect_pc_i = rpc;
    imem_gnt_i    = gnt;
    instr_ready_i = rdy;
    imem_rvalid_i = (mem_cnt == 1);
    imem_rdata_i  = imem_rvalid_i ? (mem_addr ^ XMASK) : $urandom();
    #1;
    exp_req   = !outst && (q.size() < DEPTH) && !redir;
    exp_addr  = fetch_pc;
    exp_valid = (q.size() != 0) && !redir;
    if (q.size() != 0) last_head = q[0];
    exp_pc    = last_head[63:32];
    exp_instr = last_head[31:0];
  endtask

  // Advance through the rising edge, updating model and memory.
  task automatic step();
    logic        dreq;
    logic [31:0] daddr;
    dreq  = imem_req_o;
    daddr = imem_addr_o;
    @(posedge clk_i);
    if (redirect_i) begin
      q.delete();
      fetch_pc = redirect_pc_i;
      if (outst) begin
        if (imem_rvalid_i) begin outst = 0; stale = 0; end
        else stale = 1;
      end
    end else begin
      if (exp_valid && instr_ready_i) void'(q.pop_front());
      if (outst && imem_rvalid_i) begin
        if (!stale) q.push_back({pend_pc + 32'd4, imem_rdata_i});
        outst = 0;
        stale = 0;
      end else if (!outst && exp_req && imem_gnt_i) begin
        pend_pc  = fetch_pc;
        fetch_pc = fetch_pc + 32'd4;
        outst    = 1;
      end
    end
    if (imem_rvalid_i) mem_cnt = 0;
    else if (mem_cnt > 1) mem_cnt--;
    if (dreq && imem_gnt_i) begin
      mem_cnt  = $urandom_range(lat_max, lat_min);
      mem_addr = daddr;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; instr_ready_i = 0; redirect_pc_i = '0;
    mem_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({imem_req_o, instr_valid_o, instr_o, pc_o, imem_addr_o} !== {1'b0, 1'b0, 32'd0, 32'd0, RESET_PC}) begin
      failures++;
      $display("FAIL reset_values got req=%b v=%b instr=%h pc=%h addr=%h", imem_req_o, instr_valid_o, instr_o, pc_o, imem_addr_o);
    end
    do_reset();
  endtask

  task automatic test_basic();
    int g0 = -1, v0 = -1, ng = 0;
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int c = 0; c < 16; c++) begin
      drive(0, '0, 1, 1);
      checks++;
      if ({imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o} !== {exp_req, exp_addr, exp_valid, exp_instr, exp_pc}) begin
        failures++; $display("FAIL basic_cycle c=%0d %s", c, diff_str());
      end
      if (imem_req_o) begin
        if (g0 < 0) g0 = c;
        checks++;
        if (imem_addr_o !== 32'(ng * 4)) begin
          failures++; $display("FAIL basic_addr got %h want %h", imem_addr_o, 32'(ng * 4));
        end
        ng++;
      end
      if (instr_valid_o && v0 < 0) v0 = c;
      step();
    end
    checks++;
    if (g0 < 0 || v0 != g0 + 2) begin
      failures++; $display("FAIL basic_latency got valid_cycle=%0d want %0d", v0, g0 + 2);
    end
  endtask

  task automatic test_stall();
    int  pops = 0;
    bit  found = 0;
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int c = 0; c < 20; c++) begin
      drive(0, '0, 1, 0);
      checks++;
      if ({imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o} !== {exp_req, exp_addr, exp_valid, exp_instr, exp_pc}) begin
        failures++; $display("FAIL stall_cycle c=%0d %s", c, diff_str());
      end
      step();
    end
    for (int c = 0; c < 10; c++) begin
      drive(0, '0, 1, 1);
      if (c == 0) begin
        checks++;
        if ({imem_req_o, instr_valid_o, pc_o} !== {1'b0, 1'b1, 32'd4}) begin
          failures++; $display("FAIL stall_hold got req=%b v=%b pc=%h want req=0 v=1 pc=00000004", imem_req_o, instr_valid_o, pc_o);
        end
      end
      checks++;
      if ({imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o} !== {exp_req, exp_addr, exp_valid, exp_instr, exp_pc}) begin
        failures++; $display("FAIL stall_release c=%0d %s", c, diff_str());
      end
      if (c < 4 && instr_valid_o) pops++;
      if (imem_req_o && !found) begin
        found = 1;
        checks++;
        if (imem_addr_o !== 32'd16) begin
          failures++; $display("FAIL stall_resume_addr got %h want 00000010", imem_addr_o);
        end
      end
      step();
    end
    checks++;
    if (pops != 4 || !found) begin
      failures++; $display("FAIL stall_pops got pops=%0d resumed=%0d want pops=4 resumed=1", pops, found);
    end
  endtask

  task automatic test_redirect_wait();
    bit found = 0, gotv = 0;
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int c = 0; c < 22; c++) begin
      if (c == 1) drive(1, 32'h0000_0100, 1, 1);
      else        drive(0, '0, 1, 1);
      checks++;
      if ({imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o} !== {exp_req, exp_addr, exp_valid, exp_instr, exp_pc}) begin
        failures++; $display("FAIL redir_wait_cycle c=%0d %s", c, diff_str());
      end
      if (c > 1 && imem_req_o && !found) begin
        found = 1;
        checks++;
        if (imem_addr_o !== 32'h100) begin
          failures++; $display("FAIL redir_wait_addr got %h want 00000100", imem_addr_o);
        end
      end
      if (instr_valid_o && !gotv) begin
        gotv = 1;
        checks++;
        if ({pc_o, instr_o} !== {32'h104, 32'h100 ^ XMASK}) begin
          failures++; $display("FAIL redir_wait_first got pc=%h instr=%h want pc=00000104 instr=%h", pc_o, instr_o, 32'h100 ^ XMASK);
        end
      end
      step();
    end
    checks++;
    if (!found || !gotv) begin
      failures++; $display("FAIL redir_wait_timeout got req_seen=%0d valid_seen=%0d want 1 1", found, gotv);
    end
  endtask

  task automatic test_redirect_collide();
    bit hit = 0;
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (q.size() == 2 && mem_cnt == 1) begin
        hit = 1;
        drive(1, 32'h0000_0200, 1, 1);
        checks++;
        if ({imem_req_o, instr_valid_o} !== 2'b00) begin
          failures++; $display("FAIL collide_cycle got req=%b v=%b want 0 0", imem_req_o, instr_valid_o);
        end
      end else begin
        drive(0, '0, 1, 0);
        checks++;
        if ({imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o} !== {exp_req, exp_addr, exp_valid, exp_instr, exp_pc}) begin
          failures++; $display("FAIL collide_fill c=%0d %s", c, diff_str());
        end
      end
      step();
    end
    drive(0, '0, 1, 1);
    checks++;
    if (!hit || {imem_req_o, imem_addr_o, instr_valid_o} !== {1'b1, 32'h200, 1'b0}) begin
      failures++; $display("FAIL collide_after got hit=%0d req=%b addr=%h v=%b want 1 1 00000200 0", hit, imem_req_o, imem_addr_o, instr_valid_o);
    end
    step();
    for (int c = 0; c < 6; c++) begin
      drive(0, '0, 1, 1);
      checks++;
      if ({imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o} !== {exp_req, exp_addr, exp_valid, exp_instr, exp_pc}) begin
        failures++; $display("FAIL collide_run c=%0d %s", c, diff_str());
      end
      step();
    end
  endtask

  task automatic test_wrap();
    int ng = 0;
    bit gotv = 0;
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) drive(1, 32'hFFFF_FFFC, 1, 1);
      else        drive(0, '0, 1, 1);
      checks++;
      if ({imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o} !== {exp_req, exp_addr, exp_valid, exp_instr, exp_pc}) begin
        failures++; $display("FAIL wrap_cycle c=%0d %s", c, diff_str());
      end
      if (c > 0 && imem_req_o) begin
        ng++;
        if (ng == 2) begin
          checks++;
          if (imem_addr_o !== 32'h0) begin
            failures++; $display("FAIL wrap_addr got %h want 00000000", imem_addr_o);
          end
        end
      end
      if (instr_valid_o && !gotv) begin
        gotv = 1;
        checks++;
        if ({pc_o, instr_o} !== {32'h0, 32'hFFFF_FFFC ^ XMASK}) begin
          failures++; $display("FAIL wrap_pc got pc=%h instr=%h want pc=00000000 instr=%h", pc_o, instr_o, 32'hFFFF_FFFC ^ XMASK);
        end
      end
      step();
    end
    checks++;
    if (ng < 2 || !gotv) begin
      failures++; $display("FAIL wrap_timeout got grants=%0d valid_seen=%0d want >=2 1", ng, gotv);
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 0, found = 0;
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int c = 0; c < 30 && !hit; c++) begin
      drive(0, '0, 1, 0);
      checks++;
      if ({imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o} !== {exp_req, exp_addr, exp_valid, exp_instr, exp_pc}) begin
        failures++; $display("FAIL rmid_fill c=%0d %s", c, diff_str());
      end
      if (q.size() == 3 && outst) hit = 1;
      else step();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (!hit || {imem_req_o, instr_valid_o, instr_o, pc_o, imem_addr_o} !== {1'b0, 1'b0, 32'd0, 32'd0, RESET_PC}) begin
      failures++; $display("FAIL rmid_values got hit=%0d req=%b v=%b instr=%h pc=%h addr=%h", hit, imem_req_o, instr_valid_o, instr_o, pc_o, imem_addr_o);
    end
    redirect_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; instr_ready_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    mem_cnt  = 1;               // late response from the killed fetch
    mem_addr = 32'h0000_0040;
    @(negedge clk_i);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      drive(0, '0, (c != 0), 1);
      checks++;
      if ({imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o} !== {exp_req, exp_addr, exp_valid, exp_instr, exp_pc}) begin
        failures++; $display("FAIL rmid_after c=%0d %s", c, diff_str());
      end
      if (c > 0 && imem_req_o && !found) begin
        found = 1;
        checks++;
        if (imem_addr_o !== RESET_PC) begin
          failures++; $display("FAIL rmid_restart got %h want %h", imem_addr_o, RESET_PC);
        end
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    bit redir;
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int c = 0; c < 1500; c++) begin
      redir = ($urandom_range(0, 19) == 0);
      rpc   = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0;
      drive(redir, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      checks++;
      if ({imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o} !== {exp_req, exp_addr, exp_valid, exp_instr, exp_pc}) begin
        failures++; $display("FAIL random_cycle c=%0d %s", c, diff_str());
      end
      step();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_collide();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
